// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the ripple-carry full adder slice.
// Holds the legal WIDTH range so the top and any wrappers agree on it.
package full_adder_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand, enable and result bundle shared between the adder and whatever drives it.
// The master supplies operands/carry-in/enable; the slave (the adder) returns both result paths.
interface full_adder_if #(parameter int WIDTH = 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             en;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  modport master (
    output a, b, c, en,
    input  sum, carry, sum_q, carry_q, valid_q
  );

  modport slave (
    input  a, b, c, en,
    output sum, carry, sum_q, carry_q, valid_q
  );

endinterface

// File: rtl/full_adder_fa_cell.sv
// Single-bit full adder cell; the wide adder is a ripple chain of these.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder: combinational sum/carry plus a registered copy captured on en.
// X/Z on the operands propagate through the cells untouched.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst_n,
  full_adder_if.slave bus
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("full_adder: WIDTH=%0d outside legal range %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             valid_reg;

  // k[i] is the carry into bit i; k[WIDTH] is the carry-out of the whole chain.
  assign k[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (k[i]),
      .s  (s[i]),
      .co (k[i+1])
    );
  end

  assign bus.sum   = s;
  assign bus.carry = k[WIDTH];

  // Result values hold while en is low; valid marks only the cycle after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.en;
      if (bus.en) begin
        sum_reg   <= s;
        carry_reg <= k[WIDTH];
      end
    end
  end

  assign bus.sum_q   = sum_reg;
  assign bus.carry_q = carry_reg;
  assign bus.valid_q = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 32 with a queue-based scoreboard.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  bus1 ();
  full_adder_if #(.WIDTH(8))  bus8 ();
  full_adder_if #(.WIDTH(32)) bus32 ();

  full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  full_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {valid, carry, sum} expected after the next edge.
  logic [33:0] sb1[$];
  logic [33:0] sb8[$];
  logic [33:0] sb32[$];
  logic [32:0] held1, held8, held32;
  logic [32:0] comb1, comb8, comb32;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [32:0] addModel(input int width, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
    logic [63:0] mask;
    logic [63:0] total;
    mask  = (64'd1 << width) - 64'd1;
    total = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
    return {total[width], total[31:0] & mask[31:0]};
  endfunction

  task automatic applyStimulus();
    logic [31:0] ra, rb;
    logic        rc, re;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); re = ($urandom_range(0, 3) != 0);
    bus1.a = ra[0]; bus1.b = rb[0]; bus1.c = rc; bus1.en = re;
    comb1 = addModel(1, ra, rb, rc);
    if (re) held1 = comb1;
    sb1.push_back({re, held1});

    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); re = ($urandom_range(0, 3) != 0);
    bus8.a = ra[7:0]; bus8.b = rb[7:0]; bus8.c = rc; bus8.en = re;
    comb8 = addModel(8, ra, rb, rc);
    if (re) held8 = comb8;
    sb8.push_back({re, held8});

    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); re = ($urandom_range(0, 3) != 0);
    bus32.a = ra; bus32.b = rb; bus32.c = rc; bus32.en = re;
    comb32 = addModel(32, ra, rb, rc);
    if (re) held32 = comb32;
    sb32.push_back({re, held32});
  endtask

  task automatic checkRegistered();
    logic [33:0] e;
    checkOutput("sb1_depth", 64'(sb1.size()), 64'd1);
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      checkOutput("reg1", {bus1.valid_q, bus1.carry_q, bus1.sum_q}, {e[33], e[32], e[0]});
    end
    checkOutput("sb8_depth", 64'(sb8.size()), 64'd1);
    if (sb8.size() != 0) begin
      e = sb8.pop_front();
      checkOutput("reg8", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, {e[33], e[32], e[7:0]});
    end
    checkOutput("sb32_depth", 64'(sb32.size()), 64'd1);
    if (sb32.size() != 0) begin
      e = sb32.pop_front();
      checkOutput("reg32", {bus32.valid_q, bus32.carry_q, bus32.sum_q}, {e[33], e[32], e[31:0]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] truth [8];
    logic [2:0] abc;
    // Truth table rows in abc order, each stored as {sum, carry}.
    truth = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    rst_n = 1'b0;
    bus1.a = '0;  bus1.b = '0;  bus1.c = 1'b0;  bus1.en = 1'b0;
    bus8.a = '0;  bus8.b = '0;  bus8.c = 1'b0;  bus8.en = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.c = 1'b0; bus32.en = 1'b0;
    #2;
    checkOutput("reset_q8", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, 64'd0);
    checkOutput("reset_q32", {bus32.valid_q, bus32.carry_q, bus32.sum_q}, 64'd0);
    bus8.a = 8'h03; bus8.b = 8'h04;
    #1;
    checkOutput("reset_comb8", {bus8.carry, bus8.sum}, 64'h007);

    @(negedge clk);
    rst_n = 1'b1;
    bus8.a = '0; bus8.b = '0;

    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      bus1.a = abc[2]; bus1.b = abc[1]; bus1.c = abc[0];
      #10;
      checkOutput($sformatf("truth_%0d", i), {bus1.sum, bus1.carry}, truth[i]);
    end
    checkOutput("truth_no_valid", bus1.valid_q, 1'b0);

    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1; bus1.en = 1'b1;
    @(posedge clk); #1;
    checkOutput("cap1", {bus1.valid_q, bus1.carry_q, bus1.sum_q}, 3'b111);
    bus1.en = 1'b0;

    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c = 1'b0;
    #1;
    checkOutput("wrap8_a", {bus8.carry, bus8.sum}, 9'h100);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1;
    #1;
    checkOutput("wrap8_b", {bus8.carry, bus8.sum}, 9'h1FF);
    bus32.a = 32'hFFFF_FFFF; bus32.b = 32'hFFFF_FFFF; bus32.c = 1'b1;
    #1;
    checkOutput("wrap32", {bus32.carry, bus32.sum}, 33'h1_FFFF_FFFF);

    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.c = 1'b0; bus8.en = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_cap", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, 10'h246);
    @(negedge clk);
    bus8.en = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h11;
    @(posedge clk); #1;
    checkOutput("hold_q", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, 10'h046);
    checkOutput("hold_comb", {bus8.carry, bus8.sum}, 9'h0BB);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_q", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, 64'd0);
    bus8.a = 8'h05; bus8.b = 8'h03;
    #1;
    checkOutput("areset_comb", {bus8.carry, bus8.sum}, 9'h008);
    @(negedge clk);
    rst_n = 1'b1;
    bus8.a = 8'h20; bus8.b = 8'h01; bus8.c = 1'b1; bus8.en = 1'b1;
    @(posedge clk); #1;
    checkOutput("recapture", {bus8.valid_q, bus8.carry_q, bus8.sum_q}, 10'h222);

    // Random phase starts from a fresh reset so the hold model begins at zero.
    @(negedge clk);
    bus1.en = 1'b0; bus8.en = 1'b0; bus32.en = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    held1 = '0; held8 = '0; held32 = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      applyStimulus();
      #1;
      checkOutput("rnd_comb1", {bus1.carry, bus1.sum}, {comb1[32], comb1[0]});
      checkOutput("rnd_comb8", {bus8.carry, bus8.sum}, {comb8[32], comb8[7:0]});
      checkOutput("rnd_comb32", {bus32.carry, bus32.sum}, comb32);
      @(posedge clk); #1;
      checkRegistered();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
